serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial ripple adder. It is the inverse-operation companion to the combinational full subtractor.
- Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
- Adds the operands LSB-first, one bit per clock, using a single full-adder cell and a carry flop.
- Returns the sum and carry-out through a second valid/ready handshake.
- Used where area matters more than latency, and as a sequential reference for the add/subtract datapath checks.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2 to 32).

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, operands a, b and cin are valid.
- in_ready, output, 1, block can accept operands.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in.
- out_valid, output, 1, sum and cout are valid.
- out_ready, input, 1, consumer accepts the result.
- sum, output, WIDTH, a + b + cin, modulo 2^WIDTH.
- cout, output, 1, carry out of the MSB.
- busy, output, 1, high in SHIFT and DONE.

Behaviour:
- Reset values, applied at any edge where reset=1: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, internal shift registers, carry and bit counter all 0.
- Reset takes priority over every other event and aborts any operation in progress. Partial results are discarded and never presented.
- State IDLE:
  - in_ready=1, busy=0.
  - On an edge with in_valid=1: capture a into shift register A, b into B, cin into the carry flop; clear the counter; go to SHIFT.
- State SHIFT:
  - in_ready=0, busy=1.
  - Each edge: s = A[0] ^ B[0] ^ carry; carry <= majority(A[0], B[0], carry); A and B shift right by one; s shifts into the sum register MSB with a right shift; counter increments.
  - After the edge that processes bit WIDTH-1 (counter reaches WIDTH-1): go to DONE.
- State DONE:
  - out_valid=1, busy=1, in_ready=0.
  - sum and cout hold stable until an edge with out_ready=1, then go to IDLE with out_valid=0.
  - No new operand is accepted in the same cycle as the result handshake.
- Latency: with the input handshake at edge T, out_valid is high in the cycle after edge T+WIDTH. Minimum throughput is one operation per WIDTH+2 cycles.
- sum and cout are registered outputs. Only their DONE value is meaningful, but they must not glitch while out_valid=1.
- in_valid while busy is ignored. Operands are neither captured nor queued.
- out_ready while not in DONE has no effect.
- Overflow wraps modulo 2^WIDTH; cout carries the overflow bit.
- cin=1 with a=b=all ones gives sum all ones and cout=1.
- The bench checks sum and cout against the golden model {cout, sum} = a + b + cin at the output handshake.

Test Plan:
- WIDTH=8, reset, then a=0x35, b=0x1A, cin=0 handshaken at edge T:
  - out_valid rises after edge T+8.
  - sum=0x4F, cout=0.
  - in_ready low from T+1 until return to IDLE.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Backpressure: out_ready held low for 5 cycles after out_valid rises:
  - out_valid, sum and cout stay constant.
  - in_ready stays 0.
  - Result is accepted on the first out_ready=1 edge, and in_ready=1 the next cycle.
- in_valid pulsed with a=0xAA, b=0x55 during SHIFT:
  - These operands are ignored.
  - The result is that of the original operands.
- reset asserted at bit 4 of 0x35+0x1A:
  - All outputs return to reset values at the next edge.
  - No out_valid follows.
  - A subsequent 0x10+0x20 gives sum=0x30, cout=0.
- Randomized: 200 random a, b, cin with random out_ready stalls; every result must match the golden model.

Source files
------------

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. Two WIDTH-bit operands and a carry-in are taken
// through a valid/ready handshake. They are added LSB-first, one bit per clock,
// using a single full-adder cell and a carry flop. The WIDTH-bit sum and the
// carry-out are then offered through a second valid/ready handshake.
//
// Timing: if the input handshake happens at edge T, out_valid is high in the
// cycle after edge T+WIDTH. One operation completes at most every WIDTH+2
// cycles.
//
// Ports
//   clk        : single clock, all logic on the rising edge
//   reset      : synchronous, active-high; aborts any operation in progress
//   in_valid   : a, b and cin are valid
//   in_ready   : block can accept operands (high only in IDLE)
//   a, b       : WIDTH-bit operands
//   cin        : carry-in
//   out_valid  : sum and cout are valid (high only in DONE)
//   out_ready  : consumer accepts the result
//   sum        : a + b + cin modulo 2^WIDTH (registered)
//   cout       : carry out of the MSB (registered)
//   busy       : high while shifting or holding a result
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8  // legal range 2..32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;

  // Single full-adder cell working on the current LSBs.
  logic bit_sum, bit_carry, last_bit;

  assign bit_sum   = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_carry = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign last_bit  = (cnt == LAST_BIT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Return to IDLE only; a new operand is accepted no earlier than the
        // following edge.
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shift registers, carry flop, sum register, bit counter
  // ---------------------------------------------------------------------------
  // NOTE: these are plain registers, not a memory array, so every one of them
  // can and does take the reset value; a partial sum can never leak out after
  // an aborted operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            sum_sr <= '0;
            cout_q <= 1'b0;
            cnt    <= '0;
          end
        end
        S_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          // Sum bits enter at the MSB, so after WIDTH shifts bit 0 of the
          // result has reached position 0.
          sum_sr <= {bit_sum, sum_sr[WIDTH-1:1]};
          carry  <= bit_carry;
          cnt    <= cnt + 1'b1;
          if (last_bit) cout_q <= bit_carry;
        end
        default: ;  // DONE holds the result stable
      endcase
    end
  end

  assign sum  = sum_sr;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH=8). Inputs change on the falling
// edge and outputs are sampled on the falling edge, half a cycle away from the
// active rising edge. Expected results come from plain arithmetic:
// {cout, sum} = a + b + cin.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " in_ready"},  in_ready,  1'b1);
    chk({tag, " out_valid"}, out_valid, 1'b0);
    chk({tag, " busy"},      busy,      1'b0);
  endtask

  // One complete operation, starting and ending at a falling edge in IDLE.
  // stall   : cycles out_ready is held low after out_valid rises
  // noise   : drive random in_valid/out_ready/operands while shifting
  // pulse_k : if nonzero, pulse in_valid with 0xAA/0x55 after shift edge k
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input int stall, input bit noise,
                        input int pulse_k, input string tag);
    logic [W:0] expv;
    expv = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tcin};

    chk({tag, " ready before"}, in_ready, 1'b1);
    a = ta; b = tb; cin = tcin; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);  // handshake edge T has passed
    in_valid = 1'b0;

    for (int k = 1; k <= W; k++) begin
      // Still inside SHIFT: poke inputs that must have no effect.
      if (noise) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
      end
      if (pulse_k != 0 && k == pulse_k) begin
        in_valid = 1'b1; a = 8'hAA; b = 8'h55;
      end
      @(negedge clk);  // after edge T+k
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk($sformatf("%s out_valid@T+%0d", tag, k), out_valid, (k == W));
      chk($sformatf("%s in_ready@T+%0d", tag, k),  in_ready,  1'b0);
      chk($sformatf("%s busy@T+%0d", tag, k),      busy,      1'b1);
    end

    chk({tag, " sum"},  sum,  expv[W-1:0]);
    chk({tag, " cout"}, cout, expv[W]);

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, " stall out_valid"}, out_valid, 1'b1);
      chk({tag, " stall in_ready"},  in_ready,  1'b0);
      chk({tag, " stall sum"},       sum,       expv[W-1:0]);
      chk({tag, " stall cout"},      cout,      expv[W]);
    end

    out_ready = 1'b1;
    @(negedge clk);  // result accepted on this edge
    out_ready = 1'b0;
    chk_idle({tag, " after accept"});
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    int           rs;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk_idle("reset");
    chk("reset sum",  sum,  '0);
    chk("reset cout", cout, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(8'h35, 8'h1A, 1'b0, 0, 1'b0, 0, "35+1A");
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 0, "FF+01");
    run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, 0, "FF+FF+1");
    run_op(8'h00, 8'h00, 1'b1, 0, 1'b0, 0, "00+00+1");

    // Backpressure: out_ready low for 5 cycles after out_valid rises
    run_op(8'h35, 8'h1A, 1'b0, 5, 1'b0, 0, "backpressure");

    // in_valid pulsed with other operands in the middle of SHIFT
    run_op(8'h35, 8'h1A, 1'b0, 0, 1'b0, 3, "ignore pulse");

    // Reset in the middle of an operation (after bit 3, while bit 4 is next)
    a = 8'h35; b = 8'h1A; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);  // edge T
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-abort busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("abort");
    chk("abort sum",  sum,  '0);
    chk("abort cout", cout, 1'b0);
    reset = 1'b0;
    begin
      int seen_valid;
      seen_valid = 0;
      for (int k = 0; k < W + 4; k++) begin
        @(negedge clk);
        if (out_valid === 1'b1) seen_valid++;
      end
      chk("abort no out_valid", 64'(seen_valid), 64'd0);
    end
    run_op(8'h10, 8'h20, 1'b0, 0, 1'b0, 0, "10+20 after abort");

    // Randomized operations with random stalls and input noise while shifting
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = int'($urandom_range(0, 3));
      run_op(ra, rb, rc, rs, 1'b1, 0, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
